pc_fetch_unit: RTL and testbench



---
 rtl/rv32_pkg.sv | 21 ++
 rtl/next_pc_gen.sv | 41 ++++
 rtl/pc_fetch_unit.sv | 133 +++++++++++++
 tb/tb_pc_fetch_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I front-end definitions: branch codes, NOP encoding, fetch FSM states.
package rv32_pkg;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_JAL  = 3'b001;
    localparam logic [2:0] BR_JALR = 3'b010;
    localparam logic [2:0] BR_EQ   = 3'b100;
    localparam logic [2:0] BR_NE   = 3'b101;
    localparam logic [2:0] BR_LT   = 3'b110;
    localparam logic [2:0] BR_GE   = 3'b111;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/next_pc_gen.sv
// Combinational next-PC resolver: sequential, jal, jalr and conditional branches.
module next_pc_gen
    import rv32_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [2:0]        branch,
    input  logic              zero,
    input  logic              less,
    input  logic [31:0]       imm,
    input  logic [31:0]       rs1_val,
    output logic [ADDR_W-1:0] next_pc,
    output logic              taken
);

    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] tgt_pc;
    logic [ADDR_W-1:0] jalr_sum;

    assign seq_pc   = pc + ADDR_W'(4);
    assign tgt_pc   = pc + ADDR_W'(imm);
    assign jalr_sum = ADDR_W'(rs1_val) + ADDR_W'(imm);

    always_comb begin
        next_pc = seq_pc;
        case (branch)
            BR_JAL:  next_pc = tgt_pc;
            BR_JALR: next_pc = {jalr_sum[ADDR_W-1:1], 1'b0};
            BR_EQ:   next_pc = zero  ? tgt_pc : seq_pc;
            BR_NE:   next_pc = !zero ? tgt_pc : seq_pc;
            BR_LT:   next_pc = less  ? tgt_pc : seq_pc;
            BR_GE:   next_pc = !less ? tgt_pc : seq_pc;
            default: next_pc = seq_pc;
        endcase
    end

    // "Taken" means any redirect away from the fall-through address.
    assign taken = (next_pc != seq_pc);

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: PC register, imem req/ack fetch FSM, retire-time redirect.
// Optional retire/taken counters when PC_FETCH_STATS_EN is defined.
module pc_fetch_unit
    import rv32_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    input  logic              exec_done,
    input  logic [2:0]        branch,
    input  logic              zero,
    input  logic              less,
    input  logic [31:0]       imm,
    input  logic [31:0]       rs1_val,
    output logic              misalign
`ifdef PC_FETCH_STATS_EN
    ,
    output logic [31:0]       retire_cnt,
    output logic [31:0]       taken_cnt
`endif
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic              misalign_q, misalign_d;

    logic [ADDR_W-1:0] next_pc;
    logic              taken;
    logic              retire;
    logic              bad_target;

    next_pc_gen #(
        .ADDR_W (ADDR_W)
    ) u_next_pc_gen (
        .pc      (pc_q),
        .branch  (branch),
        .zero    (zero),
        .less    (less),
        .imm     (imm),
        .rs1_val (rs1_val),
        .next_pc (next_pc),
        .taken   (taken)
    );

    assign retire     = (state_q == ST_ISSUE) && exec_done;
    assign bad_target = (next_pc[1:0] != 2'b00);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RST;
            pc_q       <= RESET_PC;
            instr_q    <= NOP;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        misalign_d = misalign_q;
        case (state_q)
            ST_RST:   state_d = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (exec_done) begin
                    if (bad_target) begin
                        misalign_d = 1'b1;
                        state_d    = ST_HALT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_RST;
        endcase
    end

    // Request and valid are pure state decodes, so they change on the same edge as the FSM.
    assign imem_req    = (state_q == ST_FETCH);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == ST_ISSUE);
    assign instr       = instr_q;
    assign pc          = pc_q;
    assign misalign    = misalign_q;

`ifdef PC_FETCH_STATS_EN
    logic [31:0] retire_cnt_q;
    logic [31:0] taken_cnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            retire_cnt_q <= '0;
            taken_cnt_q  <= '0;
        end else if (retire) begin
            if (retire_cnt_q != '1)
                retire_cnt_q <= retire_cnt_q + 32'd1;
            // A misaligned redirect is not a taken branch: the PC never moves.
            if (taken && !bad_target && taken_cnt_q != '1)
                taken_cnt_q <= taken_cnt_q + 32'd1;
        end
    end

    assign retire_cnt = retire_cnt_q;
    assign taken_cnt  = taken_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = retire ^ taken;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit (stats counters checked when PC_FETCH_STATS_EN is set).
module tb_pc_fetch_unit;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic        exec_done;
    logic [2:0]  branch;
    logic        zero;
    logic        less;
    logic [31:0] imm;
    logic [31:0] rs1_val;
    logic        misalign;
`ifdef PC_FETCH_STATS_EN
    logic [31:0] retire_cnt;
    logic [31:0] taken_cnt;
`endif

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    pc_fetch_unit #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .exec_done   (exec_done),
        .branch      (branch),
        .zero        (zero),
        .less        (less),
        .imm         (imm),
        .rs1_val     (rs1_val),
        .misalign    (misalign)
`ifdef PC_FETCH_STATS_EN
        ,
        .retire_cnt  (retire_cnt),
        .taken_cnt   (taken_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_fetch(input logic [31:0] word);
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack   = 1'b0;
    endtask

    task automatic do_retire(input logic [2:0] br, input logic z, input logic l,
                             input logic [31:0] im, input logic [31:0] rs1);
        exec_done = 1'b1;
        branch    = br;
        zero      = z;
        less      = l;
        imm       = im;
        rs1_val   = rs1;
        tick();
        exec_done = 1'b0;
        branch    = 3'b000;
    endtask

    initial begin
        reset = 1'b0; imem_ack = 1'b0; imem_rdata = '0; exec_done = 1'b0;
        branch = '0; zero = 1'b0; less = 1'b0; imm = '0; rs1_val = '0;
        tick(); tick();
        check("rst_pc",       pc,                 32'h0);
        check("rst_instr",    instr,              32'h0000_0013);
        check("rst_valid",    {31'd0, instr_valid}, 32'd0);
        check("rst_req",      {31'd0, imem_req},    32'd0);
        check("rst_misalign", {31'd0, misalign},    32'd0);

        reset = 1'b1;
        #1 check("rst_state_req", {31'd0, imem_req}, 32'd0);
        tick();
        check("fetch0_req",  {31'd0, imem_req}, 32'd1);
        check("fetch0_addr", imem_addr,         32'h0);

        do_fetch(32'h0050_0093);
        check("zw_valid", {31'd0, instr_valid}, 32'd1);
        check("zw_instr", instr,                32'h0050_0093);
        check("zw_pc",    pc,                   32'h0);
        check("zw_req",   {31'd0, imem_req},    32'd0);

        do_retire(3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
        check("seq_valid", {31'd0, instr_valid}, 32'd0);
        check("seq_addr",  imem_addr,            32'h4);

        // Delayed ack; an exec_done during FETCH must be ignored.
        for (int i = 0; i < 5; i++) begin
            check("wait_req",  {31'd0, imem_req}, 32'd1);
            check("wait_addr", imem_addr,         32'h4);
            if (i == 2) begin
                exec_done = 1'b1; branch = 3'b001; imm = 32'h40;
            end
            tick();
            exec_done = 1'b0; branch = 3'b000;
        end
        do_fetch(32'h00A0_0113);
        check("dly_instr", instr,                32'h00A0_0113);
        check("dly_valid", {31'd0, instr_valid}, 32'd1);
        check("dly_pc",    pc,                   32'h4);
        imem_rdata = 32'h1234_5678;
        tick();
        check("dly_hold_instr", instr,                32'h00A0_0113);
        check("dly_hold_valid", {31'd0, instr_valid}, 32'd1);
        check("dly_hold_req",   {31'd0, imem_req},    32'd0);

        do_retire(3'b001, 1'b0, 1'b0, 32'h0000_00FC, 32'h0);
        check("jal_addr", imem_addr, 32'h100);
        do_fetch(32'h0000_0063);
        do_retire(3'b100, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0);
        check("beq_t_addr", imem_addr, 32'hF0);
        do_fetch(32'h0000_0063);
        do_retire(3'b001, 1'b0, 1'b0, 32'h10, 32'h0);
        check("jal_back", imem_addr, 32'h100);
        do_fetch(32'h0000_0063);
        do_retire(3'b100, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0);
        check("beq_nt_addr", imem_addr, 32'h104);
        do_fetch(32'h0000_0063);
        do_retire(3'b110, 1'b0, 1'b1, 32'h8, 32'h0);
        check("blt_t_addr", imem_addr, 32'h10C);
        do_fetch(32'h0000_0063);
        do_retire(3'b111, 1'b0, 1'b1, 32'h40, 32'h0);
        check("bge_nt_addr", imem_addr, 32'h110);
        do_fetch(32'h0000_0063);
        do_retire(3'b101, 1'b1, 1'b0, 32'h40, 32'h0);
        check("bne_nt_addr", imem_addr, 32'h114);
        do_fetch(32'h0000_0063);
        do_retire(3'b011, 1'b1, 1'b1, 32'h40, 32'h0);
        check("br011_addr", imem_addr, 32'h118);
        do_fetch(32'h0000_006F);
        do_retire(3'b001, 1'b0, 1'b0, 32'hFFFF_FEE4, 32'h0);
        check("jal_top_addr", imem_addr, 32'hFFFF_FFFC);
        do_fetch(32'h0000_006F);
        check("top_pc", pc, 32'hFFFF_FFFC);
        do_retire(3'b001, 1'b0, 1'b0, 32'h4, 32'h0);
        check("wrap_addr", imem_addr,         32'h0);
        check("wrap_req",  {31'd0, imem_req}, 32'd1);

        // Reset in the middle of a fetch, with the ack arriving while reset is low.
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        #1 reset = 1'b0;
        #1;
        check("arst_valid", {31'd0, instr_valid}, 32'd0);
        check("arst_req",   {31'd0, imem_req},    32'd0);
        check("arst_instr", instr,                32'h0000_0013);
        check("arst_pc",    pc,                   32'h0);
        tick();
        check("arst_ack_drop", instr, 32'h0000_0013);
        imem_ack = 1'b0;

        reset = 1'b1;
        tick();
        check("rst2_req", {31'd0, imem_req}, 32'd1);
`ifdef PC_FETCH_STATS_EN
        check("stat_rst_retire", retire_cnt, 32'd0);
        check("stat_rst_taken",  taken_cnt,  32'd0);
`endif
        do_fetch(32'h0000_1063);
        do_retire(3'b101, 1'b0, 1'b0, 32'h20, 32'h0);
        check("bne_t_addr", imem_addr, 32'h20);
        do_fetch(32'h0000_0013);
        do_retire(3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
        check("seq2_addr", imem_addr, 32'h24);
        do_fetch(32'h0000_0013);
        do_retire(3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
        check("seq3_addr", imem_addr, 32'h28);
`ifdef PC_FETCH_STATS_EN
        check("stat_retire3", retire_cnt, 32'd3);
        check("stat_taken1",  taken_cnt,  32'd1);
`endif
        do_fetch(32'h0000_0067);
        do_retire(3'b010, 1'b0, 1'b0, 32'h4, 32'h203);
        check("mis_flag",  {31'd0, misalign},    32'd1);
        check("mis_pc",    pc,                   32'h28);
        check("mis_valid", {31'd0, instr_valid}, 32'd0);
        imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exec_done = 1'b1;
            tick();
            check("halt_req",      {31'd0, imem_req},    32'd0);
            check("halt_valid",    {31'd0, instr_valid}, 32'd0);
            check("halt_misalign", {31'd0, misalign},    32'd1);
            check("halt_pc",       pc,                   32'h28);
        end
        imem_ack = 1'b0; exec_done = 1'b0;
`ifdef PC_FETCH_STATS_EN
        check("stat_retire_mis", retire_cnt, 32'd4);
        check("stat_taken_mis",  taken_cnt,  32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
